inst_fetcher: RTL and testbench

- Front end of the out-of-order core. Produces the if_to_dc_* instruction stream consumed by the combinational decoder.
- Fetches 32-bit instruction words from the memory controller and buffers them in a small instruction queue.
- Presents one instruction per cycle to decode when the ROB, RS and LSB all have room.
- Redirects to a new PC on a ROB flush.

---
 rtl/inst_fetcher_pkg.sv | 31 +++
 rtl/inst_fetcher_if.sv | 40 ++++
 rtl/inst_fetcher_inst_queue.sv | 75 +++++++
 rtl/inst_fetcher.sv | 156 +++++++++++++++
 tb/tb_inst_fetcher.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared types for the instruction fetch front end: bus widths,
// instruction-queue entry layout and the fetch FSM state encoding.
package inst_fetcher_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam int OP_W   = 7;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [INST_W-1:0] inst_t;
    typedef logic [OP_W-1:0]   op_t;

    // One buffered instruction together with the PC it was fetched from
    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } iq_entry_t;

    // WAIT owns a live request; DISCARD owns a request whose data is stale
    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_WAIT,
        FETCH_DISCARD
    } fetch_state_t;

    // Major opcode field used by the decoder to pick an instruction class
    function automatic op_t opcode_of(input inst_t inst);
        return inst[OP_W-1:0];
    endfunction

endpackage

// File: rtl/inst_fetcher_if.sv
// Memory-controller request/response and decoder issue signals of the
// fetch unit, grouped so the fetcher and its neighbours share one bundle.
interface inst_fetcher_if;
    import inst_fetcher_pkg::*;

    logic  if_to_mc_valid;
    addr_t if_to_mc_addr;
    logic  mc_to_if_done;
    inst_t mc_to_if_inst;

    logic  if_to_dc_ready;
    addr_t if_to_dc_PC;
    inst_t if_to_dc_inst;
    op_t   if_to_dc_opType;

    // Fetcher side
    modport master (
        output if_to_mc_valid,
        output if_to_mc_addr,
        input  mc_to_if_done,
        input  mc_to_if_inst,
        output if_to_dc_ready,
        output if_to_dc_PC,
        output if_to_dc_inst,
        output if_to_dc_opType
    );

    // Memory controller / decoder side
    modport slave (
        input  if_to_mc_valid,
        input  if_to_mc_addr,
        output mc_to_if_done,
        output mc_to_if_inst,
        input  if_to_dc_ready,
        input  if_to_dc_PC,
        input  if_to_dc_inst,
        input  if_to_dc_opType
    );

endinterface

// File: rtl/inst_fetcher_inst_queue.sv
// Small circular FIFO of fetched instructions. Flush wins over push and pop;
// a simultaneous push and pop leaves the occupancy unchanged.
module inst_queue
    import inst_fetcher_pkg::*;
#(
    parameter int DEPTH_LOG = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 push,
    input  iq_entry_t            push_entry,
    input  logic                 pop,
    output iq_entry_t            head_entry,
    output logic [DEPTH_LOG:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    typedef logic [DEPTH_LOG-1:0] ptr_t;
    typedef logic [DEPTH_LOG:0]   cnt_t;

    iq_entry_t entries_q [DEPTH];
    iq_entry_t entries_d [DEPTH];
    ptr_t      head_q, head_d;
    ptr_t      tail_q, tail_d;
    cnt_t      count_q, count_d;

    // Next pointer/occupancy/storage state; pointers wrap naturally at DEPTH
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                entries_d[tail_q] = push_entry;
                tail_d            = tail_q + ptr_t'(1);
            end
            if (pop) begin
                head_d = head_q + ptr_t'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Queue state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    assign head_entry = entries_q[head_q];
    assign count      = count_q;

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch front end: keeps one memory request in flight, buffers
// returned words in a small queue and issues one instruction per cycle to the
// decoder while the ROB, RS and LSB have room. A ROB flush redirects the PC.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int    IQ_DEPTH_LOG = 2,
    parameter addr_t RESET_PC     = 32'h0
) (
    input  logic  clk_in,
    input  logic  rst_in,
    input  logic  rdy_in,
    input  logic  rob_full,
    input  logic  rs_full,
    input  logic  lsb_full,
    input  logic  rob_clear,
    input  addr_t rob_new_pc,
    inst_fetcher_if.master bus
);

    localparam int IQ_DEPTH = 1 << IQ_DEPTH_LOG;

    typedef logic [IQ_DEPTH_LOG:0] cnt_t;

    fetch_state_t state_q, state_d;
    addr_t        pc_q, pc_d;
    logic         mc_valid_q, mc_valid_d;
    addr_t        mc_addr_q, mc_addr_d;
    logic         dc_ready_q, dc_ready_d;
    addr_t        dc_pc_q, dc_pc_d;
    inst_t        dc_inst_q, dc_inst_d;
    op_t          dc_op_q, dc_op_d;

    logic         q_flush;
    logic         q_push;
    logic         q_pop;
    iq_entry_t    q_push_entry;
    iq_entry_t    q_head;
    cnt_t         q_count;
    logic         can_issue;

    inst_queue #(
        .DEPTH_LOG (IQ_DEPTH_LOG)
    ) u_queue (
        .clk        (clk_in),
        .rst_n      (rst_in),
        .flush      (q_flush),
        .push       (q_push),
        .push_entry (q_push_entry),
        .pop        (q_pop),
        .head_entry (q_head),
        .count      (q_count)
    );

    assign can_issue = (q_count != '0) && !rob_full && !rs_full && !lsb_full && !rob_clear;

    // Fetch FSM, PC update and issue selection; nothing moves while rdy_in is low
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mc_valid_d   = mc_valid_q;
        mc_addr_d    = mc_addr_q;
        dc_ready_d   = dc_ready_q;
        dc_pc_d      = dc_pc_q;
        dc_inst_d    = dc_inst_q;
        dc_op_d      = dc_op_q;
        q_flush      = 1'b0;
        q_push       = 1'b0;
        q_pop        = 1'b0;
        q_push_entry = '{pc: pc_q, inst: bus.mc_to_if_inst};

        if (rdy_in) begin
            dc_ready_d = 1'b0;
            if (can_issue) begin
                q_pop      = 1'b1;
                dc_ready_d = 1'b1;
                dc_pc_d    = q_head.pc;
                dc_inst_d  = q_head.inst;
                dc_op_d    = opcode_of(q_head.inst);
            end
            q_flush = rob_clear;

            case (state_q)
                FETCH_IDLE: begin
                    if (rob_clear) begin
                        pc_d = rob_new_pc;
                    end else if (q_count < cnt_t'(IQ_DEPTH)) begin
                        state_d    = FETCH_WAIT;
                        mc_valid_d = 1'b1;
                        mc_addr_d  = pc_q;
                    end
                end
                FETCH_WAIT: begin
                    if (rob_clear) begin
                        pc_d = rob_new_pc;
                        if (bus.mc_to_if_done) begin
                            state_d    = FETCH_IDLE;
                            mc_valid_d = 1'b0;
                        end else begin
                            state_d = FETCH_DISCARD;
                        end
                    end else if (bus.mc_to_if_done) begin
                        q_push     = 1'b1;
                        pc_d       = pc_q + 32'd4;
                        state_d    = FETCH_IDLE;
                        mc_valid_d = 1'b0;
                    end
                end
                FETCH_DISCARD: begin
                    if (rob_clear) begin
                        pc_d = rob_new_pc;
                    end
                    if (bus.mc_to_if_done) begin
                        state_d    = FETCH_IDLE;
                        mc_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d    = FETCH_IDLE;
                    mc_valid_d = 1'b0;
                end
            endcase
        end
    end

    // FSM state, PC and all registered outputs
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= FETCH_IDLE;
            pc_q       <= RESET_PC;
            mc_valid_q <= 1'b0;
            mc_addr_q  <= '0;
            dc_ready_q <= 1'b0;
            dc_pc_q    <= '0;
            dc_inst_q  <= '0;
            dc_op_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mc_valid_q <= mc_valid_d;
            mc_addr_q  <= mc_addr_d;
            dc_ready_q <= dc_ready_d;
            dc_pc_q    <= dc_pc_d;
            dc_inst_q  <= dc_inst_d;
            dc_op_q    <= dc_op_d;
        end
    end

    assign bus.if_to_mc_valid  = mc_valid_q;
    assign bus.if_to_mc_addr   = mc_addr_q;
    assign bus.if_to_dc_ready  = dc_ready_q;
    assign bus.if_to_dc_PC     = dc_pc_q;
    assign bus.if_to_dc_inst   = dc_inst_q;
    assign bus.if_to_dc_opType = dc_op_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: acts as memory controller and decoder, keeps a
// queue of instructions that must reach decode in order, and walks through
// normal fetch, back-pressure, flush, stall and asynchronous-reset cases.
module tb_inst_fetcher;
    import inst_fetcher_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_full;
    logic        rs_full;
    logic        lsb_full;
    logic        rob_clear;
    logic [31:0] rob_new_pc;

    inst_fetcher_if bus();

    inst_fetcher #(
        .IQ_DEPTH_LOG (2),
        .RESET_PC     (32'h0)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .rob_full   (rob_full),
        .rs_full    (rs_full),
        .lsb_full   (lsb_full),
        .rob_clear  (rob_clear),
        .rob_new_pc (rob_new_pc),
        .bus        (bus)
    );

    // Free-running 10 ns clock
    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  op;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          delay;
        logic [6:0]  op;
    } vec_t;

    exp_t sb[$];
    int   tests_run       = 0;
    int   tests_failed    = 0;
    bit   expect_no_issue = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Advance to the next falling edge and check any instruction handed to decode
    task automatic tick();
        exp_t e;
        @(negedge clk_in);
        if (bus.if_to_dc_ready === 1'b1) begin
            if (expect_no_issue) begin
                checkOutput("ready_while_blocked", 32'(bus.if_to_dc_ready), 32'h0);
            end else if (sb.size() == 0) begin
                checkOutput("unexpected_ready", 32'(bus.if_to_dc_ready), 32'h0);
            end else begin
                e = sb.pop_front();
                checkOutput("dc_pc", bus.if_to_dc_PC, e.pc);
                checkOutput("dc_inst", bus.if_to_dc_inst, e.inst);
                checkOutput("dc_op", 32'(bus.if_to_dc_opType), 32'(e.op));
            end
        end
    endtask

    task automatic wait_request();
        int waited = 0;
        while (bus.if_to_mc_valid !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        checkOutput("req_valid", 32'(bus.if_to_mc_valid), 32'h1);
    endtask

    // Memory controller: answer the pending request after 'delay' cycles
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] inst,
                                 input int delay, input logic [6:0] op, input bit keep);
        exp_t e;
        wait_request();
        checkOutput("req_addr", bus.if_to_mc_addr, addr);
        for (int i = 0; i < delay; i++) begin
            tick();
            checkOutput("hold_valid", 32'(bus.if_to_mc_valid), 32'h1);
            checkOutput("hold_addr", bus.if_to_mc_addr, addr);
        end
        bus.mc_to_if_inst = inst;
        bus.mc_to_if_done = 1'b1;
        if (keep) begin
            e.pc   = addr;
            e.inst = inst;
            e.op   = op;
            sb.push_back(e);
        end
        tick();
        bus.mc_to_if_done = 1'b0;
    endtask

    task automatic apply_reset();
        rst_in            = 1'b0;
        rdy_in            = 1'b1;
        rob_full          = 1'b0;
        rs_full           = 1'b0;
        lsb_full          = 1'b0;
        rob_clear         = 1'b0;
        rob_new_pc        = 32'h0;
        bus.mc_to_if_done = 1'b0;
        bus.mc_to_if_inst = 32'h0;
        expect_no_issue   = 1'b0;
        tick();
        tick();
        sb.delete();
        rst_in = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_mc_valid"}, 32'(bus.if_to_mc_valid), 32'h0);
        checkOutput({tag, "_mc_addr"}, bus.if_to_mc_addr, 32'h0);
        checkOutput({tag, "_dc_ready"}, 32'(bus.if_to_dc_ready), 32'h0);
        checkOutput({tag, "_dc_pc"}, bus.if_to_dc_PC, 32'h0);
        checkOutput({tag, "_dc_inst"}, bus.if_to_dc_inst, 32'h0);
        checkOutput({tag, "_dc_op"}, 32'(bus.if_to_dc_opType), 32'h0);
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{32'h00, 32'h00500093, 3, 7'h13};
        vecs[1] = '{32'h04, 32'h002081b3, 0, 7'h33};
        vecs[2] = '{32'h08, 32'h0000a103, 1, 7'h03};
        vecs[3] = '{32'h0c, 32'h0020a223, 2, 7'h23};
        vecs[4] = '{32'h10, 32'h00208463, 0, 7'h63};
        vecs[5] = '{32'h14, 32'h008000ef, 1, 7'h6f};
        vecs[6] = '{32'h18, 32'h123452b7, 0, 7'h37};

        // Reset values and a straight run of fetches
        apply_reset();
        check_all_zero("reset");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].pc, vecs[i].inst, vecs[i].delay, vecs[i].op, 1'b1);
            if (i == 0) begin
                checkOutput("first_ready_early", 32'(bus.if_to_dc_ready), 32'h0);
                tick();
                checkOutput("first_ready", 32'(bus.if_to_dc_ready), 32'h1);
            end
        end
        tick();
        tick();
        checkOutput("run_drained", 32'(sb.size()), 32'h0);
        checkOutput("run_next_valid", 32'(bus.if_to_mc_valid), 32'h1);
        checkOutput("run_next_addr", bus.if_to_mc_addr, 32'h1c);

        // Fill the queue under ROB back-pressure, then drain it in a burst
        apply_reset();
        rob_full        = 1'b1;
        expect_no_issue = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(32'(k * 4), 32'h00000093 | (32'(k + 1) << 20) | (32'(k + 1) << 7), 1, 7'h13, 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("full_no_request", 32'(bus.if_to_mc_valid), 32'h0);
        end
        rob_full        = 1'b0;
        expect_no_issue = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("burst_ready", 32'(bus.if_to_dc_ready), 32'h1);
        end
        checkOutput("burst_drained", 32'(sb.size()), 32'h0);
        tick();
        checkOutput("burst_end_ready", 32'(bus.if_to_dc_ready), 32'h0);
        checkOutput("burst_next_valid", 32'(bus.if_to_mc_valid), 32'h1);
        checkOutput("burst_next_addr", bus.if_to_mc_addr, 32'h10);

        // Redirect while a request to address 8 is outstanding
        apply_reset();
        applyStimulus(32'h0, 32'h00500093, 1, 7'h13, 1'b1);
        applyStimulus(32'h4, 32'h002081b3, 0, 7'h33, 1'b1);
        wait_request();
        checkOutput("flush_wait_addr", bus.if_to_mc_addr, 32'h8);
        tick();
        rob_clear  = 1'b1;
        rob_new_pc = 32'h100;
        sb.delete();
        tick();
        rob_clear = 1'b0;
        checkOutput("discard_valid", 32'(bus.if_to_mc_valid), 32'h1);
        checkOutput("discard_addr", bus.if_to_mc_addr, 32'h8);
        checkOutput("flush_ready", 32'(bus.if_to_dc_ready), 32'h0);
        tick();
        tick();
        bus.mc_to_if_inst = 32'hdeadbeef;
        bus.mc_to_if_done = 1'b1;
        tick();
        bus.mc_to_if_done = 1'b0;
        checkOutput("discard_done_valid", 32'(bus.if_to_mc_valid), 32'h0);
        applyStimulus(32'h100, 32'h0000a103, 2, 7'h03, 1'b1);
        tick();
        tick();
        checkOutput("redirect_drained", 32'(sb.size()), 32'h0);

        // Redirect in the same cycle the memory answers
        apply_reset();
        wait_request();
        checkOutput("clr_done_addr", bus.if_to_mc_addr, 32'h0);
        bus.mc_to_if_inst = 32'h00500093;
        bus.mc_to_if_done = 1'b1;
        rob_clear         = 1'b1;
        rob_new_pc        = 32'h200;
        tick();
        bus.mc_to_if_done = 1'b0;
        rob_clear         = 1'b0;
        checkOutput("clr_done_valid", 32'(bus.if_to_mc_valid), 32'h0);
        tick();
        checkOutput("clr_done_ready", 32'(bus.if_to_dc_ready), 32'h0);
        checkOutput("clr_done_relaunch", 32'(bus.if_to_mc_valid), 32'h1);
        checkOutput("clr_done_new_addr", bus.if_to_mc_addr, 32'h200);
        applyStimulus(32'h200, 32'h002081b3, 0, 7'h33, 1'b1);
        tick();
        tick();
        checkOutput("clr_done_drained", 32'(sb.size()), 32'h0);

        // Global stall mid-request with a response arriving during the stall
        apply_reset();
        wait_request();
        rdy_in = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            if (s == 1) begin
                bus.mc_to_if_inst = 32'h12345678;
                bus.mc_to_if_done = 1'b1;
            end
            if (s == 2) begin
                bus.mc_to_if_done = 1'b0;
            end
            checkOutput("stall_valid", 32'(bus.if_to_mc_valid), 32'h1);
            checkOutput("stall_addr", bus.if_to_mc_addr, 32'h0);
        end
        rdy_in = 1'b1;
        tick();
        tick();
        checkOutput("stall_resume_valid", 32'(bus.if_to_mc_valid), 32'h1);
        checkOutput("stall_resume_addr", bus.if_to_mc_addr, 32'h0);
        applyStimulus(32'h0, 32'h00500093, 1, 7'h13, 1'b1);
        tick();
        tick();
        checkOutput("stall_drained", 32'(sb.size()), 32'h0);

        // Asynchronous reset between clock edges while waiting on memory
        apply_reset();
        applyStimulus(32'h0, 32'h00500093, 0, 7'h13, 1'b1);
        wait_request();
        checkOutput("areset_wait_addr", bus.if_to_mc_addr, 32'h4);
        #2;
        rst_in = 1'b0;
        #1;
        check_all_zero("areset");
        tick();
        sb.delete();
        rst_in = 1'b1;
        wait_request();
        checkOutput("areset_first_addr", bus.if_to_mc_addr, 32'h0);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
